trax_move_rx: RTL

- UART receive-and-parse front end for the Trax player. Sits directly upstream of the Trax core.
- Deserialises 8N1 bytes from the referee on rx and parses ASCII lines in Trax notation into the core's 22-bit move word {tile[1:0], col[9:0], row[9:0]}.
- Also parses the colour-assignment line, and pulses strobes the core edge-detects to start a turn.

---
 rtl/trax_move_rx.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/trax_move_rx.sv
// trax_move_rx: UART receiver and Trax-notation line parser feeding the Trax core.
// Deserialises 8N1 bytes from the referee. Parses move lines "<col><row><tile>\n" into
// {tile[1:0], col[9:0], row[9:0]}. Parses colour lines "W\n" / "B\n".
// Optional macro TRAX_RX_PARITY_EN switches the frame format to 8E1 with a parity check.
module trax_move_rx #(
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned ROW_DIGITS_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [21:0] move_out,
  output logic        move_valid,
  output logic        color,
  output logic        color_valid,
  output logic        parse_err,
  output logic        frame_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam int unsigned DigW = $clog2(ROW_DIGITS_MAX + 1);
  localparam logic [DigW-1:0] DigMax = DigW'(ROW_DIGITS_MAX);

  localparam logic [7:0] ChLf     = 8'h0A;
  localparam logic [7:0] ChCr     = 8'h0D;
  localparam logic [7:0] ChAt     = 8'h40;
  localparam logic [7:0] ChZ      = 8'h5A;
  localparam logic [7:0] ChW      = 8'h57;
  localparam logic [7:0] ChB      = 8'h42;
  localparam logic [7:0] Ch0      = 8'h30;
  localparam logic [7:0] Ch9      = 8'h39;
  localparam logic [7:0] ChPlus   = 8'h2B;
  localparam logic [7:0] ChSlash  = 8'h2F;
  localparam logic [7:0] ChBslash = 8'h5C;

`ifdef TRAX_RX_PARITY_EN
  typedef enum logic [2:0] {UrIdle, UrStart, UrData, UrParity, UrStop} uart_e;
`else
  typedef enum logic [2:0] {UrIdle, UrStart, UrData, UrStop} uart_e;
`endif

  typedef enum logic [2:0] {PsLineStart, PsColorEnd, PsRow, PsMoveEnd, PsDiscard} parse_e;

  // Synchroniser and edge-detect history
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // UART state
  uart_e           uart_q, uart_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_stb_q, byte_stb_d;
  logic            frm_bad_q, frm_bad_d;
`ifdef TRAX_RX_PARITY_EN
  logic            par_err_q, par_err_d;
`endif

  // Parser state
  parse_e          ps_q, ps_d;
  logic [9:0]      col_q, col_d;
  logic [9:0]      row_q, row_d;
  logic [DigW-1:0] dig_q, dig_d;
  logic [1:0]      tile_q, tile_d;
  logic            color_pend_q, color_pend_d;
  logic [21:0]     move_out_q, move_out_d;
  logic            move_valid_q, move_valid_d;
  logic            color_q, color_d;
  logic            color_valid_q, color_valid_d;
  logic            parse_err_q, parse_err_d;

  logic [7:0]      rx_byte;
  logic            is_digit;
  logic            is_tile;
  logic [1:0]      tile_code;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // UART bit-timing FSM: start detect, mid-bit sampling, stop/parity check
  always_comb begin
    uart_d     = uart_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_stb_d = 1'b0;
    frm_bad_d  = 1'b0;
`ifdef TRAX_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    unique case (uart_q)
      UrIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          uart_d = UrStart;
          cnt_d  = '0;
        end
      end
      UrStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d  = '0;
          bit_d  = '0;
          // A high sample mid-start-bit is a glitch, not a frame
          uart_d = rx_sync_q ? UrIdle : UrData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UrData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef TRAX_RX_PARITY_EN
            uart_d = UrParity;
`else
            uart_d = UrStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef TRAX_RX_PARITY_EN
      UrParity: begin
        if (cnt_q == CntFull) begin
          cnt_d     = '0;
          // Even parity: data plus parity bit must XOR to zero
          par_err_d = ^{rx_sync_q, shift_q};
          uart_d    = UrStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      UrStop: begin
        if (cnt_q == CntFull) begin
          cnt_d  = '0;
          // Return at mid-stop so a back-to-back start edge is not missed
          uart_d = UrIdle;
`ifdef TRAX_RX_PARITY_EN
          if (rx_sync_q && !par_err_q) byte_stb_d = 1'b1;
          else                         frm_bad_d  = 1'b1;
`else
          if (rx_sync_q) byte_stb_d = 1'b1;
          else           frm_bad_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: uart_d = UrIdle;
    endcase
  end

  // UART state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_q     <= UrIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_stb_q <= 1'b0;
      frm_bad_q  <= 1'b0;
`ifdef TRAX_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      uart_q     <= uart_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_stb_q <= byte_stb_d;
      frm_bad_q  <= frm_bad_d;
`ifdef TRAX_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // shift_q is stable for a whole bit time after the strobe, so it serves as the byte
  assign rx_byte  = shift_q;
  assign is_digit = (rx_byte >= Ch0) && (rx_byte <= Ch9);
  assign is_tile  = (rx_byte == ChPlus) || (rx_byte == ChSlash) || (rx_byte == ChBslash);

  // Tile encoding: '+' -> 01, '/' -> 10, '\' -> 11
  always_comb begin
    tile_code = 2'b00;
    if (rx_byte == ChPlus)   tile_code = 2'b01;
    if (rx_byte == ChSlash)  tile_code = 2'b10;
    if (rx_byte == ChBslash) tile_code = 2'b11;
  end

  // Line parser: one transition per received byte, pulses on the terminating '\n'
  always_comb begin
    ps_d          = ps_q;
    col_d         = col_q;
    row_d         = row_q;
    dig_d         = dig_q;
    tile_d        = tile_q;
    color_pend_d  = color_pend_q;
    move_out_d    = move_out_q;
    color_d       = color_q;
    move_valid_d  = 1'b0;
    color_valid_d = 1'b0;
    parse_err_d   = 1'b0;
    if (frm_bad_q) begin
      // Dropped byte poisons the whole line
      ps_d = PsDiscard;
    end else if (byte_stb_q) begin
      unique case (ps_q)
        PsLineStart: begin
          if (rx_byte == ChW || rx_byte == ChB) begin
            color_pend_d = (rx_byte == ChB);
            ps_d         = PsColorEnd;
          end else if (rx_byte >= ChAt && rx_byte <= ChZ) begin
            col_d = {5'd0, rx_byte[4:0]};
            row_d = '0;
            dig_d = '0;
            ps_d  = PsRow;
          end else if (rx_byte != ChCr && rx_byte != ChLf) begin
            ps_d = PsDiscard;
          end
        end
        PsColorEnd: begin
          if (rx_byte == ChLf) begin
            color_d       = color_pend_q;
            color_valid_d = 1'b1;
            ps_d          = PsLineStart;
          end else if (rx_byte != ChCr) begin
            ps_d = PsDiscard;
          end
        end
        PsRow: begin
          if (is_digit) begin
            if (dig_q == DigMax) begin
              ps_d = PsDiscard;
            end else begin
              row_d = (row_q * 10'd10) + {6'd0, rx_byte[3:0]};
              dig_d = dig_q + 1'b1;
            end
          end else if (is_tile) begin
            if (dig_q == '0) begin
              ps_d = PsDiscard;
            end else begin
              tile_d = tile_code;
              ps_d   = PsMoveEnd;
            end
          end else begin
            ps_d = PsDiscard;
          end
        end
        PsMoveEnd: begin
          if (rx_byte == ChLf) begin
            move_out_d   = {tile_q, col_q, row_q};
            move_valid_d = 1'b1;
            ps_d         = PsLineStart;
          end else if (rx_byte != ChCr) begin
            ps_d = PsDiscard;
          end
        end
        PsDiscard: begin
          if (rx_byte == ChLf) begin
            parse_err_d = 1'b1;
            ps_d        = PsLineStart;
          end
        end
        default: ps_d = PsLineStart;
      endcase
    end
  end

  // Parser and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q          <= PsLineStart;
      col_q         <= '0;
      row_q         <= '0;
      dig_q         <= '0;
      tile_q        <= '0;
      color_pend_q  <= 1'b0;
      move_out_q    <= '0;
      move_valid_q  <= 1'b0;
      color_q       <= 1'b0;
      color_valid_q <= 1'b0;
      parse_err_q   <= 1'b0;
    end else begin
      ps_q          <= ps_d;
      col_q         <= col_d;
      row_q         <= row_d;
      dig_q         <= dig_d;
      tile_q        <= tile_d;
      color_pend_q  <= color_pend_d;
      move_out_q    <= move_out_d;
      move_valid_q  <= move_valid_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
      parse_err_q   <= parse_err_d;
    end
  end

  assign move_out    = move_out_q;
  assign move_valid  = move_valid_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign parse_err   = parse_err_q;
  assign frame_err   = frm_bad_q;

endmodule
